uart_fifo_loopback: RTL and testbench
=====================================

Name: uart_fifo_loopback

Overview:
Parametrised successor to the fixed 8N1 UART loopback. A UART receiver deserialises frames from i_rx and writes the data words into a FIFO of DEPTH entries. A UART transmitter drains the FIFO and re-serialises each word onto o_tx. Baud divisor, word width, stop-bit count and FIFO depth are all parameters. The block adds framing-error detection, overflow reporting and an exported fill level.

Parameters:
BAUD_DIV, 104, clock cycles per bit (12 MHz / 115200); must be >= 4.
DATA_BITS, 8, data bits per frame (5..9), sent and received LSB first.
STOP_BITS, 1, stop bits generated by the TX (1 or 2); the RX checks only the first stop bit.
DEPTH, 16, FIFO entries; must be a power of 2, >= 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_rx  in  1  serial input; idle-high; asynchronous to i_clk
o_tx  out  1  serial output; idle-high
o_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
o_overflow  out  1  one-cycle pulse: a good word was dropped because the FIFO was full
o_frame_err  out  1  one-cycle pulse: stop bit sampled low, word dropped
o_parity_err  out  1  one-cycle pulse; exists only with UART_PARITY_EN

Behaviour:
- Reset (asynchronous, i_rst=1):
  - o_tx=1, o_level=0, all pulse outputs 0.
  - FIFO pointers cleared; RX and TX FSMs forced to IDLE; synchroniser flops set to 1.
  - Reset mid-frame aborts both frames immediately; the partial RX word is discarded.
- RX synchroniser: i_rx passes through 2 flops; all RX logic uses the synchronised signal (rx_s).
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s high->low transition -> START, bit counter cleared.
  - START: wait BAUD_DIV/2 cycles (integer division), then sample rx_s.
    - Sample 1 -> false start, return to IDLE, no pulse.
    - Sample 0 -> DATA.
  - DATA: sample every BAUD_DIV cycles, DATA_BITS samples, shifted in LSB first -> STOP.
  - STOP: sample once after BAUD_DIV cycles.
    - Sample 1 -> push request.
    - Sample 0 -> o_frame_err pulse, no push.
    - Return to IDLE in both cases; a new start edge is recognised from the next cycle.
- FIFO: registered push and pop.
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Push to a full FIFO with no pop -> word dropped, o_overflow high for exactly one cycle, contents unchanged.
  - Simultaneous push and pop -> o_level unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - o_level updates the cycle after a push or pop.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If o_level!=0: pop the head word into the shift register and enter START on the same edge.
  - START: o_tx=0 for BAUD_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, BAUD_DIV cycles each.
  - STOP: o_tx=1 for STOP_BITS*BAUD_DIV cycles.
  - Back-to-back: if the FIFO is non-empty at the end of STOP, pop the next word and go straight to START with zero idle cycles. Otherwise go to IDLE.
- Latency: the first start bit on o_tx begins 2 cycles after the push cycle of a word that arrives into an empty FIFO.
- o_tx is driven directly from a flop: no combinational path from i_rx and no glitches.

Optional Feature:
UART_PARITY_EN
- Defined:
  - Frames carry an even-parity bit between the last data bit and the stop bit, on both RX and TX.
  - RX state PARITY is inserted between DATA and STOP.
  - On parity mismatch with a good stop bit: o_parity_err pulses for one cycle and the word is not pushed.
  - If the stop bit is also bad, only o_frame_err pulses.
  - TX computes parity over the popped word.
- Undefined: no parity bit on either side; o_parity_err port is absent; frame = 1 + DATA_BITS + stop bits.

Test Plan:
- Run with BAUD_DIV=8, defaults otherwise.
  - Send 0xA5 on i_rx -> o_tx emits start, then 1,0,1,0,0,1,0,1, then stop; o_level goes 0->1->0.
  - Start bit begins 2 cycles after the push.
- Send bytes 0x00..0xFF back-to-back (1 stop) -> o_tx reproduces all 256 bytes in order, with no idle gap between TX frames while the FIFO is non-empty.
- Hold i_rx low for 3 cycles only -> no push, no pulses, o_tx stays 1.
- Send 0x3C with the stop bit forced low -> o_frame_err pulses once, o_level stays 0, and the next byte 0x5A loops back correctly.
- Set DEPTH=4 and STOP_BITS=2 with i_rx sending at 1 stop bit:
  - o_level saturates at 4, then o_overflow pulses once per dropped byte.
  - Output order matches the accepted bytes.
- Assert i_rst mid-TX-frame and mid-RX-frame -> o_tx=1 immediately, o_level=0; a following byte 0x81 loops back cleanly.
- (UART_PARITY_EN) Send 0x07 with an odd parity bit -> o_parity_err pulses once, no push; send 0x07 with parity bit 1 -> it loops back with parity bit 1.

Source files
------------

// File: rtl/uart_fifo_loopback.sv
// rtl/uart_fifo_loopback.sv - UART receiver feeding a FIFO drained by a UART transmitter
//
// Purpose:
//   Deserialises frames arriving on i_rx, stores each good data word in a
//   DEPTH-entry FIFO, and re-serialises the stored words onto o_tx. Words with
//   a low stop bit are dropped (o_frame_err). Good words that meet a full FIFO
//   are dropped (o_overflow).
//
// Parameters:
//   BAUD_DIV   clock cycles per bit (>= 4)
//   DATA_BITS  data bits per frame (5..9), LSB first
//   STOP_BITS  stop bits generated by the transmitter (1 or 2)
//   DEPTH      FIFO entries (power of 2, >= 2)
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous reset, active-high
//   i_rx          serial input, idle-high, asynchronous to i_clk
//   o_tx          serial output, idle-high, driven straight from a flop
//   o_level       FIFO occupancy, 0..DEPTH
//   o_overflow    one-cycle pulse: good word dropped, FIFO full
//   o_frame_err   one-cycle pulse: stop bit sampled low, word dropped
//   o_parity_err  one-cycle pulse: parity mismatch, word dropped (UART_PARITY_EN only)
//
// Build option:
//   UART_PARITY_EN  adds an even-parity bit between the last data bit and the
//                   stop bit on both directions, and the o_parity_err port.

module uart_fifo_loopback #(
  parameter int BAUD_DIV  = 104,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  output logic                   o_tx,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  output logic                   o_frame_err
`ifdef UART_PARITY_EN
  ,
  output logic                   o_parity_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STOP_BITS * BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] C_BIT  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_STOP = CW'(STOP_BITS * BAUD_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

  // ------------------------------------------------------------------
  // Input synchroniser and start-edge detect
  // ------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_d;
  logic w_rx_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  assign w_rx_fall = r_rx_d & ~r_rx_s;

  // ------------------------------------------------------------------
  // Receiver FSM
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  rx_state_t            r_rx_state, w_rx_state;
  logic [CW-1:0]        r_rx_cnt, w_rx_cnt;
  logic [BW-1:0]        r_rx_bit, w_rx_bit;
  logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh;
  logic                 r_push_req, w_push_req;
  logic [DATA_BITS-1:0] r_push_data, w_push_data;
  logic                 r_frame_err, w_frame_err;
`ifdef UART_PARITY_EN
  logic                 r_rx_par_bad, w_rx_par_bad;
  logic                 r_parity_err, w_parity_err;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_sh      <= '0;
      r_push_req   <= 1'b0;
      r_push_data  <= '0;
      r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_state   <= w_rx_state;
      r_rx_cnt     <= w_rx_cnt;
      r_rx_bit     <= w_rx_bit;
      r_rx_sh      <= w_rx_sh;
      r_push_req   <= w_push_req;
      r_push_data  <= w_push_data;
      r_frame_err  <= w_frame_err;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= w_rx_par_bad;
      r_parity_err <= w_parity_err;
`endif
    end
  end

  always_comb begin
    w_rx_state   = r_rx_state;
    w_rx_cnt     = r_rx_cnt + CW'(1);
    w_rx_bit     = r_rx_bit;
    w_rx_sh      = r_rx_sh;
    w_push_req   = 1'b0;
    w_push_data  = r_push_data;
    w_frame_err  = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_par_bad = r_rx_par_bad;
    w_parity_err = 1'b0;
`endif
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt = '0;
        if (w_rx_fall) begin
          w_rx_state = RX_START;
          w_rx_bit   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit check filters out glitches shorter than half a bit.
        if (r_rx_cnt == C_HALF) begin
          w_rx_cnt   = '0;
          w_rx_state = r_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == C_BIT) begin
          w_rx_cnt = '0;
          w_rx_sh  = {r_rx_s, r_rx_sh[DATA_BITS-1:1]};
          if (r_rx_bit == B_LAST) begin
`ifdef UART_PARITY_EN
            w_rx_state = RX_PARITY;
`else
            w_rx_state = RX_STOP;
`endif
          end else begin
            w_rx_bit = r_rx_bit + BW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (r_rx_cnt == C_BIT) begin
          w_rx_cnt     = '0;
          w_rx_par_bad = r_rx_s ^ (^r_rx_sh);
          w_rx_state   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (r_rx_cnt == C_BIT) begin
          w_rx_cnt   = '0;
          w_rx_state = RX_IDLE;
          if (!r_rx_s) begin
            // A bad stop bit outranks a parity mismatch.
            w_frame_err = 1'b1;
`ifdef UART_PARITY_EN
          end else if (r_rx_par_bad) begin
            w_parity_err = 1'b1;
`endif
          end else begin
            w_push_req  = 1'b1;
            w_push_data = r_rx_sh;
          end
        end
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FIFO
  // ------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_overflow;
  logic                 w_pop;
  logic                 w_push_ok;
  logic [DATA_BITS-1:0] w_head;

  assign w_head = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot the push is about to use.
  assign w_push_ok = r_push_req & ((r_level != L_FULL) | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_push_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_push_req & ~w_push_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Transmitter FSM
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t            r_tx_state, w_tx_state;
  logic [CW-1:0]        r_tx_cnt, w_tx_cnt;
  logic [BW-1:0]        r_tx_bit, w_tx_bit;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh;
  logic                 r_tx, w_tx;
`ifdef UART_PARITY_EN
  logic                 r_tx_par, w_tx_par;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_sh    <= w_tx_sh;
      r_tx       <= w_tx;
`ifdef UART_PARITY_EN
      r_tx_par   <= w_tx_par;
`endif
    end
  end

  // w_tx is the line value for the next cycle, so o_tx comes straight from r_tx.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt + CW'(1);
    w_tx_bit   = r_tx_bit;
    w_tx_sh    = r_tx_sh;
    w_tx       = r_tx;
    w_pop      = 1'b0;
`ifdef UART_PARITY_EN
    w_tx_par   = r_tx_par;
`endif
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt = '0;
        w_tx     = 1'b1;
        w_pop    = (r_level != '0);
      end
      TX_START: begin
        if (r_tx_cnt == C_BIT) begin
          w_tx_cnt   = '0;
          w_tx_bit   = '0;
          w_tx_state = TX_DATA;
          w_tx       = r_tx_sh[0];
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == C_BIT) begin
          w_tx_cnt = '0;
          if (r_tx_bit == B_LAST) begin
`ifdef UART_PARITY_EN
            w_tx_state = TX_PARITY;
            w_tx       = r_tx_par;
`else
            w_tx_state = TX_STOP;
            w_tx       = 1'b1;
`endif
          end else begin
            w_tx_bit = r_tx_bit + BW'(1);
            w_tx_sh  = r_tx_sh >> 1;
            w_tx     = r_tx_sh[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (r_tx_cnt == C_BIT) begin
          w_tx_cnt   = '0;
          w_tx_state = TX_STOP;
          w_tx       = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (r_tx_cnt == C_STOP) begin
          w_tx_cnt   = '0;
          w_tx_state = TX_IDLE;
          w_tx       = 1'b1;
          // Back-to-back frames: no idle cycle when a word is already waiting.
          w_pop      = (r_level != '0);
        end
      end
      default: w_tx_state = TX_IDLE;
    endcase

    if (w_pop) begin
      w_tx_cnt   = '0;
      w_tx_sh    = w_head;
      w_tx_state = TX_START;
      w_tx       = 1'b0;
`ifdef UART_PARITY_EN
      w_tx_par   = ^w_head;
`endif
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign o_tx        = r_tx;
  assign o_level     = r_level;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;
`ifdef UART_PARITY_EN
  assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_fifo_loopback.sv
// tb/tb_uart_fifo_loopback.sv - self-checking bench for uart_fifo_loopback
`timescale 1ns/1ps
module tb_uart_fifo_loopback;

  localparam int BAUD    = 8;
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 4;
`ifdef UART_PARITY_EN
  localparam int NPB = 1;
`else
  localparam int NPB = 0;
`endif
  localparam int RXF   = (10 + NPB) * BAUD;
  localparam int TXF_A = (10 + NPB) * BAUD;
  localparam int TXF_B = (11 + NPB) * BAUD;
  localparam int NB    = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a, rx_b;
  logic       tx_a, tx_b;
  logic [4:0] lvl_a;
  logic [2:0] lvl_b;
  logic       ovf_a, ovf_b, ferr_a, ferr_b, perr_a, perr_b;

  always #5 clk = ~clk;

  uart_fifo_loopback #(.BAUD_DIV(BAUD), .DATA_BITS(8), .STOP_BITS(1), .DEPTH(DEPTH_A)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .o_tx(tx_a), .o_level(lvl_a),
    .o_overflow(ovf_a), .o_frame_err(ferr_a)
`ifdef UART_PARITY_EN
    , .o_parity_err(perr_a)
`endif
  );

  uart_fifo_loopback #(.BAUD_DIV(BAUD), .DATA_BITS(8), .STOP_BITS(2), .DEPTH(DEPTH_B)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_b), .o_tx(tx_b), .o_level(lvl_b),
    .o_overflow(ovf_b), .o_frame_err(ferr_b)
`ifdef UART_PARITY_EN
    , .o_parity_err(perr_b)
`endif
  );

`ifndef UART_PARITY_EN
  assign perr_a = 1'b0;
  assign perr_b = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Line monitors: decode o_tx frames and count output pulses
  // ------------------------------------------------------------------
  int         cyc = 0;
  int         mst[2], mstart[2], e;
  logic [7:0] mword[2];
  int         ferr_cnt[2], ovf_cnt[2], perr_cnt[2];
  int         lvl_max[2], lvl_hi[2], lvl_prev[2], lvl_rise[2], tx_start[2], tx_low[2];
  logic [7:0] got_a[$], got_b[$];
  int         st_a[$];
  logic       m_t, m_fe, m_ov, m_pe;
  int         m_lv;

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      m_t  = (d == 0) ? tx_a : tx_b;
      m_lv = (d == 0) ? int'(lvl_a) : int'(lvl_b);
      m_fe = (d == 0) ? ferr_a : ferr_b;
      m_ov = (d == 0) ? ovf_a : ovf_b;
      m_pe = (d == 0) ? perr_a : perr_b;
      if (rst) begin
        mst[d]      = 0;
        lvl_prev[d] = 0;
      end else begin
        if (m_fe) ferr_cnt[d]++;
        if (m_ov) ovf_cnt[d]++;
        if (m_pe) perr_cnt[d]++;
        if (m_lv > lvl_max[d]) lvl_max[d] = m_lv;
        if (m_lv != 0) lvl_hi[d]++;
        if (m_lv != 0 && lvl_prev[d] == 0) lvl_rise[d] = cyc;
        lvl_prev[d] = m_lv;
        if (!m_t) tx_low[d]++;
        if (mst[d] == 0) begin
          if (!m_t) begin
            mst[d]      = 1;
            mstart[d]   = cyc;
            tx_start[d] = cyc;
            if (d == 0) st_a.push_back(cyc);
          end
        end else begin
          e = cyc - mstart[d];
          if (e == BAUD / 2) chk("tx_start_bit", int'(m_t), 0);
          for (int i = 0; i < 8; i++)
            if (e == BAUD * (1 + i) + BAUD / 2) mword[d][i] = m_t;
          if (NPB == 1 && e == BAUD * 9 + BAUD / 2) chk("tx_parity_bit", int'(m_t), int'(^mword[d]));
          if (e == BAUD * (9 + NPB) + BAUD / 2) begin
            chk("tx_stop_bit", int'(m_t), 1);
            if (d == 0) got_a.push_back(mword[d]);
            else        got_b.push_back(mword[d]);
            mst[d] = 0;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
  endtask

  // Drives up to nbits bits of one frame, each exactly BAUD cycles long.
  task automatic drive_frame(input int d, input logic [7:0] data, input logic stop_val,
                             input logic par_flip, input int nbits);
    logic [11:0] f;
    int          len;
    f         = '1;
    f[0]      = 1'b0;
    f[8:1]    = data;
    f[9]      = (^data) ^ par_flip;
    f[9+NPB]  = stop_val;
    len       = 10 + NPB;
    for (int i = 0; i < len && i < nbits; i++) begin
      @(negedge clk);
      set_rx(d, f[i]);
      repeat (BAUD - 1) @(negedge clk);
    end
  endtask

  task automatic idle_line(input int d, input int n);
    @(negedge clk);
    set_rx(d, 1'b1);
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic clear_stats();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      ferr_cnt[d] = 0; ovf_cnt[d] = 0; perr_cnt[d] = 0;
      lvl_max[d]  = 0; lvl_hi[d]  = 0; tx_low[d]   = 0;
      lvl_rise[d] = -1; tx_start[d] = -100;
    end
    got_a.delete();
    got_b.delete();
    st_a.delete();
  endtask

  // ------------------------------------------------------------------
  // Directed vectors and reference-model state
  // ------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       par_flip;
    int         exp_loop;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] vals[NB];
  logic [7:0] exp_b[$];
  int         fifo_m[$];
  int         m_busy, m_drops, m_max, m_cnt0, errs, gaps, waited;
  logic       m_pop, m_push, m_acc;

  initial begin
    rx_a = 1'b1;
    rx_b = 1'b1;
    tbl.push_back('{8'hA5, 1'b1, 1'b0, 1, 0, 0});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 0, 1, 0});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 1, 0, 0});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 1, 0, 0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 1, 0, 0});
    tbl.push_back('{8'($urandom), 1'b1, 1'b0, 1, 0, 0});
`ifdef UART_PARITY_EN
    tbl.push_back('{8'h07, 1'b1, 1'b1, 0, 0, 1});
    tbl.push_back('{8'h07, 1'b0, 1'b1, 0, 1, 0});
    tbl.push_back('{8'h07, 1'b1, 1'b0, 1, 0, 0});
`endif
    clear_stats();

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx_a", int'(tx_a), 1);
    chk("reset_level_a", int'(lvl_a), 0);
    chk("reset_tx_b", int'(tx_b), 1);
    chk("reset_level_b", int'(lvl_b), 0);
    chk("reset_pulses", int'({ovf_a, ferr_a, perr_a, ovf_b, ferr_b, perr_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_line(0, 20);

    // Table-driven single frames
    for (int k = 0; k < tbl.size(); k++) begin
      clear_stats();
      drive_frame(0, tbl[k].data, tbl[k].stop_ok, tbl[k].par_flip, 99);
      idle_line(0, 3 * TXF_A);
      chk("vec_loop_count", got_a.size(), tbl[k].exp_loop);
      if (got_a.size() > 0) chk("vec_data", int'(got_a[0]), int'(tbl[k].data));
      chk("vec_frame_err", ferr_cnt[0], tbl[k].exp_ferr);
      chk("vec_parity_err", perr_cnt[0], tbl[k].exp_perr);
      chk("vec_level_cycles", lvl_hi[0], tbl[k].exp_loop);
      if (tbl[k].exp_loop != 0) chk("vec_latency", tx_start[0] - lvl_rise[0], 1);
      else                      chk("vec_tx_quiet", tx_low[0], 0);
    end

    // Short low glitch: false start
    clear_stats();
    @(negedge clk);
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    idle_line(0, 100);
    chk("glitch_no_word", got_a.size(), 0);
    chk("glitch_no_ferr", ferr_cnt[0], 0);
    chk("glitch_level", lvl_hi[0], 0);
    chk("glitch_tx_quiet", tx_low[0], 0);

    // 256 bytes back-to-back
    clear_stats();
    for (int b = 0; b < 256; b++) drive_frame(0, 8'(b), 1'b1, 1'b0, 99);
    waited = 0;
    while (got_a.size() < 256 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    idle_line(0, 50);
    chk("sweep_count", got_a.size(), 256);
    errs = 0;
    for (int k = 0; k < got_a.size() && k < 256; k++) if (int'(got_a[k]) != k) errs++;
    chk("sweep_data_errors", errs, 0);
    gaps = 0;
    for (int k = 1; k < st_a.size(); k++) if (st_a[k] - st_a[k-1] != TXF_A) gaps++;
    chk("sweep_frame_gaps", gaps, 0);
    chk("sweep_ferr", ferr_cnt[0], 0);
    chk("sweep_overflow", ovf_cnt[0], 0);

    // Overflow: RX at one stop bit outruns TX at two. Cycle-level queue model,
    // relative to the first push: pushes every RXF cycles, a pop is possible once
    // the previous frame is done and the FIFO holds a word.
    for (int j = 0; j < NB; j++) vals[j] = 8'($urandom);
    m_busy = 0; m_drops = 0; m_max = 0;
    for (int c = 0; c < RXF * NB + TXF_B * (DEPTH_B + 3); c++) begin
      m_cnt0 = fifo_m.size();
      m_pop  = (c >= m_busy) && (m_cnt0 > 0);
      m_push = (c % RXF == 0) && (c / RXF < NB);
      m_acc  = m_push && ((m_cnt0 < DEPTH_B) || m_pop);
      if (m_pop) begin
        exp_b.push_back(vals[fifo_m.pop_front()]);
        m_busy = c + TXF_B;
      end
      if (m_acc) fifo_m.push_back(c / RXF);
      if (m_push && !m_acc) m_drops++;
      if (fifo_m.size() > m_max) m_max = fifo_m.size();
    end
    clear_stats();
    for (int j = 0; j < NB; j++) drive_frame(1, vals[j], 1'b1, 1'b0, 99);
    waited = 0;
    while (got_b.size() < exp_b.size() && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    idle_line(1, 3 * TXF_B);
    chk("ovf_count_words", got_b.size(), exp_b.size());
    errs = 0;
    for (int k = 0; k < got_b.size() && k < exp_b.size(); k++) if (got_b[k] != exp_b[k]) errs++;
    chk("ovf_order_errors", errs, 0);
    chk("ovf_pulses", ovf_cnt[1], m_drops);
    chk("ovf_level_max", lvl_max[1], m_max);
    chk("ovf_level_full", lvl_max[1], DEPTH_B);

    // Reset in the middle of a TX frame and an RX frame
    clear_stats();
    drive_frame(0, 8'h11, 1'b1, 1'b0, 99);
    drive_frame(0, 8'h22, 1'b1, 1'b0, 4);
    @(negedge clk);
    rst  = 1'b1;
    rx_a = 1'b1;
    #1;
    chk("rst_tx_immediate", int'(tx_a), 1);
    chk("rst_level_immediate", int'(lvl_a), 0);
    repeat (3) @(negedge clk);
    chk("rst_tx_held", int'(tx_a), 1);
    rst = 1'b0;
    idle_line(0, 50);
    clear_stats();
    drive_frame(0, 8'h81, 1'b1, 1'b0, 99);
    idle_line(0, 3 * TXF_A);
    chk("post_rst_count", got_a.size(), 1);
    if (got_a.size() > 0) chk("post_rst_data", int'(got_a[0]), 8'h81);
    chk("post_rst_ferr", ferr_cnt[0], 0);
    chk("post_rst_latency", tx_start[0] - lvl_rise[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
